// File: rtl/dc_offset_pkg.sv
`default_nettype none
// ============================================================================
// Module   : dc_offset_pkg
// Purpose  : Shared types, default widths and the clamped ramp-step function
//            for the multi-channel DC offset register.
// Contents : DEF_WIDTH, DEF_STEP_W  default offset and step widths
//            offs_state_e           per-channel state (OFFS_IDLE, OFFS_RAMP)
//            ramp_next()            next ramp value, never overshooting target
// Config   : DC_OFFSET_SIGNED_EN (used by the channel, not here)
// Revision : 1.0  initial release
// ============================================================================
package dc_offset_pkg;

  localparam int DEF_WIDTH  = 12;
  localparam int DEF_STEP_W = 8;

  typedef enum logic [0:0] {
    OFFS_IDLE = 1'b0,
    OFFS_RAMP = 1'b1
  } offs_state_e;

  // Operands arrive already sign- or zero-extended by the caller, so one
  // wide signed subtraction covers both number formats without wrap.
  // step == 0 means "jump straight to target".
  function automatic logic signed [63:0] ramp_next(
    input logic signed [63:0] cur,
    input logic signed [63:0] tgt,
    input logic        [63:0] step
  );
    logic signed [63:0] diff;
    logic signed [63:0] mag;
    diff = tgt - cur;
    mag  = (diff < 0) ? -diff : diff;
    if ((step == 64'd0) || (mag <= signed'(step))) begin
      return tgt;
    end else if (diff > 0) begin
      return cur + signed'(step);
    end else begin
      return cur - signed'(step);
    end
  endfunction

endpackage
`default_nettype wire

// File: rtl/dc_offset_ramp_ch.sv
`default_nettype none
// ============================================================================
// Module   : dc_offset_ramp_ch
// Purpose  : One offset channel: holds the committed target and walks the
//            output toward it in steps of at most 'step' per tick.
// Ports    : Clock, Reset        clock, synchronous active-high reset
//            commit, commit_val  load a new target this cycle
//            step, tick          step size (0 = immediate) and rate enable
//            dout                current channel offset
//            busy                channel is ramping (registered state)
//            busy_next           ramping state after the coming edge
// Config   : DC_OFFSET_SIGNED_EN  treat dout/target as two's complement
// Revision : 1.0  initial release
// ============================================================================
module dc_offset_ramp_ch
  import dc_offset_pkg::*;
#(
  parameter int WIDTH  = DEF_WIDTH,
  parameter int STEP_W = DEF_STEP_W
) (
  input  logic              Clock,
  input  logic              Reset,
  input  logic              commit,
  input  logic [WIDTH-1:0]  commit_val,
  input  logic [STEP_W-1:0] step,
  input  logic              tick,
  output logic [WIDTH-1:0]  dout,
  output logic              busy,
  output logic              busy_next
);

  offs_state_e        r_state;
  offs_state_e        w_state_next;
  logic [WIDTH-1:0]   r_target;
  logic [WIDTH-1:0]   r_dout;
  logic [WIDTH-1:0]   w_target_next;
  logic [WIDTH-1:0]   w_dout_next;
  logic signed [63:0] w_cur_ext;
  logic signed [63:0] w_tgt_ext;
  logic signed [63:0] w_ramp_val;
  logic               w_advance;
  logic               w_unused;

`ifdef DC_OFFSET_SIGNED_EN
  assign w_cur_ext = 64'(signed'(r_dout));
  assign w_tgt_ext = 64'(signed'(r_target));
`else
  assign w_cur_ext = 64'(r_dout);
  assign w_tgt_ext = 64'(r_target);
`endif

  assign w_ramp_val = ramp_next(w_cur_ext, w_tgt_ext, 64'(step));
  // The result always lies between dout and target, so the upper bits carry
  // nothing beyond sign/zero extension.
  assign w_unused   = ^w_ramp_val[63:WIDTH];

  // A zero step ignores the tick so the jump lands on the next edge.
  assign w_advance = (r_state == OFFS_RAMP) && ((step == '0) || tick);

  always_comb begin
    w_target_next = r_target;
    w_dout_next   = r_dout;
    w_state_next  = r_state;
    if (w_advance) begin
      w_dout_next = w_ramp_val[WIDTH-1:0];
    end
    // The step taken in a commit cycle still heads for the old target; the
    // new target is pursued from the next tick on. Re-arming is judged
    // against where dout will be after this edge.
    if (commit) begin
      w_target_next = commit_val;
      w_state_next  = (commit_val != w_dout_next) ? OFFS_RAMP : OFFS_IDLE;
    end else if ((r_state == OFFS_RAMP) && (w_dout_next == r_target)) begin
      w_state_next = OFFS_IDLE;
    end
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      r_state  <= OFFS_IDLE;
      r_target <= '0;
      r_dout   <= '0;
    end else begin
      r_state  <= w_state_next;
      r_target <= w_target_next;
      r_dout   <= w_dout_next;
    end
  end

  assign dout      = r_dout;
  assign busy      = (r_state == OFFS_RAMP);
  assign busy_next = (w_state_next == OFFS_RAMP);

endmodule
`default_nettype wire

// File: rtl/dc_offset_ramp_reg.sv
`default_nettype none
// ============================================================================
// Module   : dc_offset_ramp_reg
// Purpose  : Multi-channel DC offset register. Host writes per-channel
//            shadows; a global commit loads all targets at once; each channel
//            ramps to its target in bounded steps paced by 'tick'.
// Ports    : Clock, Reset    clock, synchronous active-high reset
//            wr_en/wr_ch/wr_data  shadow write (wr_ch >= CHANNELS ignored)
//            commit          load all shadows into targets (write-through)
//            step, tick      max change per tick (0 = jump), rate enable
//            Dout            channel n at [n*WIDTH +: WIDTH]
//            busy            per-channel ramping flags
//            done            one-cycle pulse when the last ramp completes
// Config   : DC_OFFSET_SIGNED_EN  two's complement offsets
// Revision : 1.0  initial release
// ============================================================================
module dc_offset_ramp_reg
  import dc_offset_pkg::*;
#(
  parameter  int WIDTH    = DEF_WIDTH,
  parameter  int CHANNELS = 2,
  parameter  int STEP_W   = DEF_STEP_W,
  localparam int CH_W     = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                      Clock,
  input  logic                      Reset,
  input  logic                      wr_en,
  input  logic [CH_W-1:0]           wr_ch,
  input  logic [WIDTH-1:0]          wr_data,
  input  logic                      commit,
  input  logic [STEP_W-1:0]         step,
  input  logic                      tick,
  output logic [CHANNELS*WIDTH-1:0] Dout,
  output logic [CHANNELS-1:0]       busy,
  output logic                      done
);

  logic [CHANNELS-1:0] w_busy_next;
  logic                r_done;

  for (genvar n = 0; n < CHANNELS; n++) begin : g_ch
    logic             w_wr_hit;
    logic [WIDTH-1:0] w_commit_val;
    logic [WIDTH-1:0] r_shadow;

    // Exact-match decode: an out-of-range index hits no channel.
    assign w_wr_hit     = wr_en && (wr_ch == CH_W'(n));
    assign w_commit_val = w_wr_hit ? wr_data : r_shadow;

    always_ff @(posedge Clock) begin
      if (Reset) begin
        r_shadow <= '0;
      end else if (w_wr_hit) begin
        r_shadow <= wr_data;
      end
    end

    dc_offset_ramp_ch #(
      .WIDTH  (WIDTH),
      .STEP_W (STEP_W)
    ) u_ch (
      .Clock      (Clock),
      .Reset      (Reset),
      .commit     (commit),
      .commit_val (w_commit_val),
      .step       (step),
      .tick       (tick),
      .dout       (Dout[n*WIDTH +: WIDTH]),
      .busy       (busy[n]),
      .busy_next  (w_busy_next[n])
    );
  end

  // Fires on the edge where the last ramp finishes; a commit that re-arms any
  // channel in the same cycle keeps busy_next high and suppresses it.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      r_done <= 1'b0;
    end else begin
      r_done <= (|busy) && !(|w_busy_next);
    end
  end

  assign done = r_done;

endmodule
`default_nettype wire
